// File: rtl/regfile_ctrl_if.sv
// Bundle of the command, register-file and response signals for regfile_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface regfile_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rm;
    logic [7:0]  cmd_imm;
    logic [15:0] rf_data_in;
    logic [2:0]  rf_writenum;
    logic        rf_write;
    logic [2:0]  rf_readnum;
    logic [15:0] rf_data_out;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_ready;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rm, cmd_imm, rf_data_out, rsp_ready,
        output cmd_ready, rf_data_in, rf_writenum, rf_write, rf_readnum, rsp_valid, rsp_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rm, cmd_imm, rf_data_out, rsp_ready,
        input  cmd_ready, rf_data_in, rf_writenum, rf_write, rf_readnum, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_ctrl.sv
// Register-file controller: accepts MOVI/MOV/RD/NOP commands one at a time,
// sequences the register-file read and write, and returns RD results through
// a valid/ready response port. Outputs are driven only by registers or by the
// state decode, so nothing on an input reaches an output combinationally.
module regfile_ctrl (
    input  logic          clk,
    input  logic          reset,
    regfile_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        OP_MOVI = 2'b00,
        OP_MOV  = 2'b01,
        OP_RD   = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    op_t         op_r;
    op_t         cmd_op_s;
    logic [15:0] data_r;
    logic [2:0]  readnum_r;
    logic [2:0]  writenum_r;
    logic        accept_s;

    // Two's-complement widening of the 8-bit immediate to the 16-bit datapath.
    function automatic logic [15:0] sext_imm(input logic [7:0] imm);
        return {{8{imm[7]}}, imm};
    endfunction

    assign cmd_op_s = op_t'(bus.cmd_op);
    // A command is taken only while idle; cmd_valid elsewhere is simply ignored.
    assign accept_s = bus.cmd_valid && (state_r == ST_IDLE);

    // State register; reset abandons whatever command is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode for the command sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op_s)
                        OP_MOVI:       state_nxt_s = ST_WRITE;
                        OP_MOV, OP_RD: state_nxt_s = ST_READ;
                        default:       state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (op_r == OP_MOV) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_WRITE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Command latch and data register; indices hold their value when unused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r       <= OP_NOP;
            data_r     <= 16'h0000;
            readnum_r  <= 3'd0;
            writenum_r <= 3'd0;
        end else begin
            if (accept_s) begin
                op_r <= cmd_op_s;
                case (cmd_op_s)
                    OP_MOVI: begin
                        data_r     <= sext_imm(bus.cmd_imm);
                        writenum_r <= bus.cmd_rd;
                    end
                    OP_MOV: begin
                        readnum_r  <= bus.cmd_rm;
                        writenum_r <= bus.cmd_rd;
                    end
                    OP_RD: begin
                        readnum_r <= bus.cmd_rm;
                    end
                    default: begin
                    end
                endcase
            end else if (state_r == ST_READ) begin
                data_r <= bus.rf_data_out;
            end
        end
    end

    assign bus.cmd_ready   = (state_r == ST_IDLE);
    assign bus.rf_write    = (state_r == ST_WRITE);
    assign bus.rsp_valid   = (state_r == ST_RESP);
    assign bus.rf_data_in  = data_r;
    assign bus.rsp_data    = data_r;
    assign bus.rf_writenum = writenum_r;
    assign bus.rf_readnum  = readnum_r;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: a behavioural 8x16 register file, a
// reference copy of its expected contents, and queues of expected writes and
// responses that are checked (value and cycle) when the DUT produces them.
module tb_regfile_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    regfile_ctrl_if bus ();

    regfile_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] rf     [8];
    logic [15:0] ref_rf [8];

    assign bus.rf_data_out = rf[bus.rf_readnum];

    typedef struct {
        logic [2:0]  num;
        logic [15:0] data;
        int          cyc;
    } wr_exp_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        logic [1:0] op;
        logic [2:0] rd;
        logic [2:0] rm;
        logic [7:0] imm;
        int         ready_lat;
    } vec_t;

    wr_exp_t  wq [$];
    rsp_exp_t rq [$];
    vec_t     vecs [11];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Evaluates the cycle about to end: commits writes to the model register
    // file and pops/compares the scoreboard for writes and response handshakes.
    task automatic monitor();
        wr_exp_t  w;
        rsp_exp_t r;
        if (bus.rf_write === 1'b1) begin
            chk("write_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                w = wq.pop_front();
                chk("wr_num",  32'(bus.rf_writenum), 32'(w.num));
                chk("wr_data", 32'(bus.rf_data_in),  32'(w.data));
                chk("wr_cyc",  32'(cyc),             32'(w.cyc));
            end
            rf[bus.rf_writenum] = bus.rf_data_in;
        end
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            chk("rsp_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("rsp_data", 32'(bus.rsp_data), 32'(r.data));
                chk("rsp_cyc",  32'(cyc),          32'(r.cyc));
            end
        end
    endtask

    task automatic step();
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rm,
                         input logic [7:0] imm);
        bus.cmd_op  = op;
        bus.cmd_rd  = rd;
        bus.cmd_rm  = rm;
        bus.cmd_imm = imm;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rm,
                           input logic [7:0] imm, input int lat);
        int          n;
        int          c0;
        wr_exp_t     w;
        rsp_exp_t    r;
        logic [15:0] sx;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
        c0 = cyc;
        sx = {{8{imm[7]}}, imm};
        case (op)
            2'b00: begin
                w.num = rd; w.data = sx; w.cyc = c0 + 1;
                wq.push_back(w);
                ref_rf[rd] = sx;
            end
            2'b01: begin
                w.num = rd; w.data = ref_rf[rm]; w.cyc = c0 + 2;
                wq.push_back(w);
                ref_rf[rd] = ref_rf[rm];
            end
            2'b10: begin
                r.data = ref_rf[rm]; r.cyc = c0 + 2;
                rq.push_back(r);
            end
            default: begin
            end
        endcase
        drive(op, rd, rm, imm);
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        if (op == 2'b01 || op == 2'b10) begin
            chk("readnum_at_plus1", 32'(bus.rf_readnum), 32'(rm));
        end
        if (op == 2'b11) begin
            chk("nop_no_write", 32'(bus.rf_write), 32'd0);
        end
        n = 1;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("ready_latency", 32'(n), 32'(lat));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"},   32'(bus.cmd_ready),   32'd1);
        chk({tag, "_rf_write"},    32'(bus.rf_write),    32'd0);
        chk({tag, "_rf_writenum"}, 32'(bus.rf_writenum), 32'd0);
        chk({tag, "_rf_readnum"},  32'(bus.rf_readnum),  32'd0);
        chk({tag, "_rf_data_in"},  32'(bus.rf_data_in),  32'd0);
        chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
        chk({tag, "_rsp_data"},    32'(bus.rsp_data),    32'd0);
    endtask

    initial begin
        int       c0;
        rsp_exp_t r;

        for (int i = 0; i < 8; i++) begin
            rf[i]     = 16'hA0A0 + 16'(i);
            ref_rf[i] = 16'hA0A0 + 16'(i);
        end

        vecs[0]  = '{2'b00, 3'd3, 3'd0, 8'h85, 2};
        vecs[1]  = '{2'b00, 3'd2, 3'd0, 8'h34, 2};
        vecs[2]  = '{2'b11, 3'd1, 3'd1, 8'hFF, 1};
        vecs[3]  = '{2'b00, 3'd0, 3'd0, 8'h01, 2};
        vecs[4]  = '{2'b00, 3'd7, 3'd0, 8'h7F, 2};
        vecs[5]  = '{2'b01, 3'd6, 3'd3, 8'h00, 3};
        vecs[6]  = '{2'b01, 3'd4, 3'd4, 8'h00, 3};
        vecs[7]  = '{2'b10, 3'd0, 3'd7, 8'h00, 3};
        vecs[8]  = '{2'b10, 3'd0, 3'd1, 8'h00, 3};
        vecs[9]  = '{2'b00, 3'd1, 3'd0, 8'h80, 2};
        vecs[10] = '{2'b10, 3'd0, 3'd1, 8'h00, 3};

        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(2'b11, 3'd0, 3'd0, 8'h00);

        // Power-on reset.
        #1 reset = 1'b1;
        #1;
        chk_reset_outputs("por");
        #10 reset = 1'b0;

        // Table-driven commands.
        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rm, vecs[i].imm, vecs[i].ready_lat);
        end
        chk("r0_after_movi", 32'(rf[0]), 32'h0001);
        chk("r7_after_movi", 32'(rf[7]), 32'h007F);
        chk("r3_after_movi", 32'(rf[3]), 32'hFF85);
        chk("r2_after_movi", 32'(rf[2]), 32'h0034);
        chk("r4_self_mov",   32'(rf[4]), 32'hA0A4);
        chk("r6_mov",        32'(rf[6]), 32'hFF85);

        // Preload R2 directly, then copy it to R5.
        rf[2]     = 16'h1234;
        ref_rf[2] = 16'h1234;
        run_cmd(2'b01, 3'd5, 3'd2, 8'h00, 3);
        chk("r5_eq_r2", 32'(rf[5]), 32'h1234);

        // RD with the consumer stalling; a new command is offered meanwhile.
        bus.rsp_ready = 1'b0;
        c0 = cyc;
        r.data = ref_rf[5];
        r.cyc  = c0 + 6;
        rq.push_back(r);
        drive(2'b10, 3'd0, 3'd5, 8'h00);
        bus.cmd_valid = 1'b1;
        step();
        drive(2'b00, 3'd1, 3'd0, 8'h55);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_rsp_data",  32'(bus.rsp_data),  32'h1234);
            chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        chk("stall_idle_ready", 32'(bus.cmd_ready), 32'd1);
        chk("stall_rsp_drop",   32'(bus.rsp_valid), 32'd0);
        chk("stall_r1_intact",  32'(rf[1]), 32'(ref_rf[1]));

        // Reset asserted mid-cycle during the write of a MOVI.
        drive(2'b00, 3'd6, 3'd0, 8'h11);
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        chk("pre_reset_write", 32'(bus.rf_write),    32'd1);
        chk("pre_reset_wnum",  32'(bus.rf_writenum), 32'd6);
        #3 reset = 1'b1;
        #1;
        chk_reset_outputs("mid");
        #2 reset = 1'b0;
        step();
        chk("r6_not_written", 32'(rf[6]), 32'(ref_rf[6]));
        run_cmd(2'b10, 3'd0, 3'd6, 8'h00, 3);

        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
